// File: rtl/bp_common_pkg.sv
// Shared definitions for the NBF stream path: default stream word width,
// the byte lane order used to assemble words, and a bytes-per-word helper.
package bp_common_pkg;

   localparam int unsigned stream_data_width_gp = 32;

   typedef enum logic {
      e_lane_little = 1'b0,
      e_lane_big    = 1'b1
   } lane_order_e;

   // First byte of a word lands in the least significant lane.
   localparam lane_order_e lane_order_gp = e_lane_little;

   function automatic int unsigned bytes_per_word(input int unsigned width);
      return width / 8;
   endfunction

endpackage

// File: rtl/bp_stream_two_fifo.sv
// Two-entry FIFO holding assembled stream words.
// Ports:
//   clk_i, reset_n_i  clock, asynchronous active-low reset
//   push_i, data_i    write side (push ignored when full)
//   pop_i             read side (pop ignored when empty)
//   data_o            head entry
//   full_o, empty_o   occupancy flags, straight from registers
module bp_stream_two_fifo #(
   parameter int unsigned width_p = 32
) (
   input  logic               clk_i,
   input  logic               reset_n_i,
   input  logic               push_i,
   input  logic [width_p-1:0] data_i,
   input  logic               pop_i,
   output logic [width_p-1:0] data_o,
   output logic               full_o,
   output logic               empty_o
);

   logic [width_p-1:0] mem_q [2];
   logic               wr_ptr_q;
   logic               rd_ptr_q;
   logic [1:0]         count_q;
   logic               push_ok;
   logic               pop_ok;

   assign full_o  = (count_q == 2'd2);
   assign empty_o = (count_q == 2'd0);
   assign push_ok = push_i & ~full_o;
   assign pop_ok  = pop_i & ~empty_o;
   assign data_o  = mem_q[rd_ptr_q];

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (push_ok) begin
            mem_q[wr_ptr_q] <= data_i;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (pop_ok) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         case ({push_ok, pop_ok})
            2'b10:   count_q <= count_q + 2'd1;
            2'b01:   count_q <= count_q - 2'd1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/bp_stream_byte_packer.sv
// Byte-serial host link to valid/ready word stream packer, feeding the NBF
// loader. Bytes are packed little-endian into stream_data_width_p words and
// queued in a 2-entry buffer. A partial word left idle for timeout_cycles_p
// cycles is discarded so a stalled host cannot leave the loader misaligned.
// Ports:
//   clk_i, reset_n_i             clock, asynchronous active-low reset
//   byte_v_i, byte_i             host byte in
//   byte_ready_o                 byte accepted this cycle when high with byte_v_i
//   stream_v_o, stream_data_o    assembled word out
//   stream_ready_i               downstream accepts the head word
//   word_count_o                 words completed (wraps)
//   drop_count_o                 partial words discarded (saturates)
//   busy_o                       a partial word is held
module bp_stream_byte_packer
   import bp_common_pkg::*;
#(
   parameter int unsigned stream_data_width_p = stream_data_width_gp,
   parameter int unsigned timeout_cycles_p    = 1048576,
   parameter int unsigned count_width_p       = 16
) (
   input  logic                           clk_i,
   input  logic                           reset_n_i,
   input  logic                           byte_v_i,
   input  logic [7:0]                     byte_i,
   output logic                           byte_ready_o,
   output logic                           stream_v_o,
   output logic [stream_data_width_p-1:0] stream_data_o,
   input  logic                           stream_ready_i,
   output logic [count_width_p-1:0]       word_count_o,
   output logic [count_width_p-1:0]       drop_count_o,
   output logic                           busy_o
);

   localparam int unsigned bytes_lp     = bytes_per_word(stream_data_width_p);
   localparam int unsigned idx_w_lp     = $clog2(bytes_lp);
   localparam logic [idx_w_lp-1:0] idx_last_lp = idx_w_lp'(bytes_lp - 1);
   localparam int unsigned idle_w_lp    = (timeout_cycles_p > 2) ? $clog2(timeout_cycles_p) : 1;
   localparam logic [idle_w_lp-1:0] idle_last_lp =
      idle_w_lp'((timeout_cycles_p == 0) ? 0 : timeout_cycles_p - 1);

   logic [idx_w_lp-1:0]            idx_q, idx_d;
   logic [stream_data_width_p-1:0] shift_q, shift_d;
   logic [idle_w_lp-1:0]           idle_q, idle_d;
   logic [count_width_p-1:0]       word_cnt_q, word_cnt_d;
   logic [count_width_p-1:0]       drop_cnt_q, drop_cnt_d;
   logic                           rdy_en_q;

   logic                           accept;
   logic                           push;
   logic                           pop;
   logic                           fifo_full;
   logic                           fifo_empty;
   logic [idx_w_lp-1:0]            lane;
   logic [stream_data_width_p-1:0] push_data;

   // Ready looks only at registered state, so stream_ready_i never reaches
   // byte_ready_o combinationally. rdy_en_q holds ready low during reset.
   assign byte_ready_o = rdy_en_q & ((idx_q != idx_last_lp) | ~fifo_full);
   assign accept       = byte_v_i & byte_ready_o;
   assign stream_v_o   = ~fifo_empty;
   assign pop          = stream_v_o & stream_ready_i;
   assign busy_o       = (idx_q != '0);
   assign word_count_o = word_cnt_q;
   assign drop_count_o = drop_cnt_q;
   assign lane         = (lane_order_gp == e_lane_little) ? idx_q : (idx_last_lp - idx_q);

   always_comb begin
      idx_d      = idx_q;
      shift_d    = shift_q;
      idle_d     = idle_q;
      word_cnt_d = word_cnt_q;
      drop_cnt_d = drop_cnt_q;
      push       = 1'b0;
      push_data  = shift_q;
      if (accept) begin
         push_data[{lane, 3'b000} +: 8] = byte_i;
         idle_d = '0;
         if (idx_q == idx_last_lp) begin
            push       = 1'b1;
            idx_d      = '0;
            shift_d    = '0;
            word_cnt_d = word_cnt_q + count_width_p'(1);
         end else begin
            idx_d   = idx_q + idx_w_lp'(1);
            shift_d = push_data;
         end
      end else if (idx_q == '0) begin
         idle_d = '0;
      end else if ((timeout_cycles_p != 0) && (idle_q == idle_last_lp)) begin
         // Stale partial word: drop it; buffered words are untouched.
         idx_d   = '0;
         shift_d = '0;
         idle_d  = '0;
         if (drop_cnt_q != '1) begin
            drop_cnt_d = drop_cnt_q + count_width_p'(1);
         end
      end else if (timeout_cycles_p != 0) begin
         idle_d = idle_q + idle_w_lp'(1);
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         idx_q      <= '0;
         shift_q    <= '0;
         idle_q     <= '0;
         word_cnt_q <= '0;
         drop_cnt_q <= '0;
         rdy_en_q   <= 1'b0;
      end else begin
         idx_q      <= idx_d;
         shift_q    <= shift_d;
         idle_q     <= idle_d;
         word_cnt_q <= word_cnt_d;
         drop_cnt_q <= drop_cnt_d;
         rdy_en_q   <= 1'b1;
      end
   end

   bp_stream_two_fifo #(
      .width_p (stream_data_width_p)
   ) u_fifo (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .push_i    (push),
      .data_i    (push_data),
      .pop_i     (pop),
      .data_o    (stream_data_o),
      .full_o    (fifo_full),
      .empty_o   (fifo_empty)
   );

endmodule

// File: tb/tb_bp_stream_byte_packer.sv
module tb_bp_stream_byte_packer;

   localparam int BPW = 4;
   localparam int TO  = 16;
   localparam int CW  = 4;

   logic          clk_i = 1'b0;
   logic          reset_n_i = 1'b1;
   logic          byte_v_i = 1'b0;
   logic [7:0]    byte_i = 8'h00;
   logic          byte_ready_o;
   logic          stream_v_o;
   logic [31:0]   stream_data_o;
   logic          stream_ready_i = 1'b0;
   logic [CW-1:0] word_count_o;
   logic [CW-1:0] drop_count_o;
   logic          busy_o;

   int checks = 0;
   int errors = 0;

   bp_stream_byte_packer #(
      .stream_data_width_p (32),
      .timeout_cycles_p    (TO),
      .count_width_p       (CW)
   ) dut (
      .clk_i          (clk_i),
      .reset_n_i      (reset_n_i),
      .byte_v_i       (byte_v_i),
      .byte_i         (byte_i),
      .byte_ready_o   (byte_ready_o),
      .stream_v_o     (stream_v_o),
      .stream_data_o  (stream_data_o),
      .stream_ready_i (stream_ready_i),
      .word_count_o   (word_count_o),
      .drop_count_o   (drop_count_o),
      .busy_o         (busy_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: the expected word stream and buffer occupancy, kept as
   // a byte queue per partial word and a word queue for the scoreboard.
   logic [31:0] sb[$];
   logic [7:0]  part[$];
   int          occ = 0;
   int          idle = 0;
   int          words = 0;
   int          drops = 0;
   bit          live = 0;
   bit          exp_rdy;
   bit          m_acc;
   logic [31:0] w;

   always @(negedge clk_i) begin
      if (!reset_n_i) begin
         part.delete();
         sb.delete();
         occ = 0; idle = 0; words = 0; drops = 0; live = 0;
      end else begin
         exp_rdy = live && !(part.size() == BPW - 1 && occ == 2);
         chk("byte_ready", 32'(byte_ready_o), 32'(exp_rdy));
         chk("stream_v", 32'(stream_v_o), 32'(occ != 0));
         chk("busy", 32'(busy_o), 32'(part.size() != 0));
         chk("word_count", 32'(word_count_o), 32'(words));
         chk("drop_count", 32'(drop_count_o), 32'(drops));
         m_acc = byte_v_i && exp_rdy;
         if (occ != 0 && stream_ready_i) occ--;
         if (m_acc) begin
            part.push_back(byte_i);
            idle = 0;
            if (part.size() == BPW) begin
               w = 32'h0;
               for (int i = 0; i < BPW; i++) w = w | (32'(part[i]) << (8 * i));
               sb.push_back(w);
               occ++;
               words = (words + 1) % (1 << CW);
               part.delete();
            end
         end else if (part.size() != 0) begin
            idle++;
            if (idle == TO) begin
               part.delete();
               idle = 0;
               if (drops < (1 << CW) - 1) drops++;
            end
         end else begin
            idle = 0;
         end
         live = 1;
      end
   end

   // Monitor: every word handed downstream must match the scoreboard head.
   logic [31:0] exp_word;
   always @(negedge clk_i) begin
      if (reset_n_i && stream_v_o && stream_ready_i) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL stream_data: got %h expected no word at %0t", stream_data_o, $time);
         end else begin
            exp_word = sb.pop_front();
            chk("stream_data", stream_data_o, exp_word);
         end
      end
   end

   task automatic idle_cycles(input int n);
      repeat (n) begin
         @(posedge clk_i);
         #1;
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      int  n;
      bit  acc;
      n = 0;
      acc = 0;
      byte_v_i = 1'b1;
      byte_i = b;
      while (!acc && n < 100) begin
         @(negedge clk_i);
         acc = byte_ready_o;
         @(posedge clk_i);
         #1;
         n++;
      end
      byte_v_i = 1'b0;
      if (!acc) begin
         checks++;
         errors++;
         $display("FAIL send_byte: byte %h never accepted within 100 cycles", b);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_ready"}, 32'(byte_ready_o), 32'h0);
      chk({tag, "_v"}, 32'(stream_v_o), 32'h0);
      chk({tag, "_data"}, stream_data_o, 32'h0);
      chk({tag, "_wc"}, 32'(word_count_o), 32'h0);
      chk({tag, "_dc"}, 32'(drop_count_o), 32'h0);
      chk({tag, "_busy"}, 32'(busy_o), 32'h0);
   endtask

   task automatic do_reset();
      byte_v_i = 1'b0;
      reset_n_i = 1'b0;
      @(negedge clk_i);
      @(posedge clk_i);
      #1;
      reset_n_i = 1'b1;
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   bit rand_done;

   initial begin
      #1 reset_n_i = 1'b0;
      #2 check_reset_outputs("init_reset");
      @(negedge clk_i);
      @(posedge clk_i);
      #1 reset_n_i = 1'b1;
      @(posedge clk_i);
      #1;

      // Basic pack
      stream_ready_i = 1'b1;
      send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
      chk("basic_v", 32'(stream_v_o), 32'h1);
      chk("basic_data", stream_data_o, 32'h12345678);
      chk("basic_wc", 32'(word_count_o), 32'h1);
      idle_cycles(2);
      chk("basic_busy", 32'(busy_o), 32'h0);

      // Back-pressure
      do_reset();
      stream_ready_i = 1'b0;
      for (int i = 0; i < 11; i++) send_byte(8'(i));
      fork
         send_byte(8'h0B);
         begin
            idle_cycles(4);
            chk("bp_ready_low", 32'(byte_ready_o), 32'h0);
            chk("bp_head", stream_data_o, 32'h03020100);
            stream_ready_i = 1'b1;
         end
      join
      idle_cycles(4);
      chk("bp_wc", 32'(word_count_o), 32'h3);

      // Timeout
      do_reset();
      send_byte(8'hAA); send_byte(8'hBB);
      idle_cycles(15);
      chk("to_before_drop", 32'(drop_count_o), 32'h0);
      idle_cycles(1);
      chk("to_drop", 32'(drop_count_o), 32'h1);
      chk("to_busy", 32'(busy_o), 32'h0);
      send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
      chk("to_word", stream_data_o, 32'h04030201);

      // Timeout tie: byte arrives in the terminal idle cycle
      do_reset();
      send_byte(8'h11);
      idle_cycles(15);
      send_byte(8'h22);
      chk("tie_drop", 32'(drop_count_o), 32'h0);
      chk("tie_busy", 32'(busy_o), 32'h1);
      send_byte(8'h33); send_byte(8'h44);
      chk("tie_word", stream_data_o, 32'h44332211);

      // Async reset mid-word with a word buffered
      do_reset();
      stream_ready_i = 1'b0;
      send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
      send_byte(8'h05); send_byte(8'h06); send_byte(8'h07);
      #2 reset_n_i = 1'b0;
      #1 check_reset_outputs("async_reset");
      @(negedge clk_i);
      @(posedge clk_i);
      #1 reset_n_i = 1'b1;
      stream_ready_i = 1'b1;
      @(posedge clk_i);
      #1;
      send_byte(8'hDD); send_byte(8'hCC); send_byte(8'hBB); send_byte(8'hAA);
      chk("ar_word", stream_data_o, 32'hAABBCCDD);
      chk("ar_wc", 32'(word_count_o), 32'h1);
      idle_cycles(2);

      // Randomized traffic with random downstream stalls and idle gaps
      do_reset();
      rand_done = 0;
      fork
         begin
            for (int i = 0; i < 200; i++) begin
               send_byte(8'($urandom_range(0, 255)));
               if ($urandom_range(0, 9) == 0) idle_cycles($urandom_range(14, 20));
               else idle_cycles($urandom_range(0, 2));
            end
            rand_done = 1;
         end
         begin
            while (!rand_done) begin
               @(posedge clk_i);
               #1;
               stream_ready_i = ($urandom_range(0, 3) != 0);
            end
         end
      join
      stream_ready_i = 1'b1;
      idle_cycles(20);

      // Counter boundary: word counter wraps, drop counter saturates
      do_reset();
      for (int i = 0; i < 17 * BPW; i++) send_byte(8'(i));
      idle_cycles(3);
      chk("wc_wrap", 32'(word_count_o), 32'h1);
      for (int i = 0; i < 17; i++) begin
         send_byte(8'hE0);
         idle_cycles(TO);
      end
      chk("dc_sat", 32'(drop_count_o), 32'hF);
      idle_cycles(3);
      chk("sb_drained", 32'(sb.size()), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule

// File: doc/bp_stream_byte_packer.md
Name: bp_stream_byte_packer

Overview:
- Upstream feeder for the NBF stream loader.
- Accepts a byte-serial host link (UART/JTAG-bridge style bytes) and assembles little-endian stream_data_width_p words.
- Presents the words on the valid/ready stream interface that the loader's stream_v_i / stream_data_i / stream_ready_o port consumes.
- Recovers word alignment after a stalled host by discarding a partial word on an idle timeout.

Parameters:
- stream_data_width_p, 32, output word width; multiple of 8, at least 16.
- timeout_cycles_p, 1048576, idle cycles with a partial word before it is discarded; 0 disables the timeout.
- count_width_p, 16, width of the word and drop counters.

Ports:
- clk_i  input  1  clock
- reset_n_i  input  1  reset; asynchronous, active-low
- byte_v_i  input  1  host byte valid
- byte_i  input  8  host byte
- byte_ready_o  output  1  packer accepts byte_i this cycle (ready-valid)
- stream_v_o  output  1  assembled word available
- stream_data_o  output  stream_data_width_p  assembled word
- stream_ready_i  input  1  downstream (NBF loader) accepts word
- word_count_o  output  count_width_p  words pushed to the output buffer; wraps
- drop_count_o  output  count_width_p  partial words discarded by timeout; saturates at all-ones
- busy_o  output  1  partial word held (byte index != 0)

Behaviour:
- Clock and reset:
  - One clock.
  - Reset is asynchronous, active-low: reset_n_i low clears all state immediately, independent of clk_i. Release is synchronous to clk_i.
  - While reset is asserted: byte_ready_o=0, stream_v_o=0, stream_data_o=0, word_count_o=0, drop_count_o=0, busy_o=0, byte index=0, idle counter=0, output buffer empty.
  - Reset mid-word or with words buffered discards everything and does not increment drop_count_o.
- Assembly:
  - bytes_per_word B = stream_data_width_p/8. Byte index idx counts 0..B-1.
  - An accepted byte (byte_v_i & byte_ready_o) is written to lane idx, bits [8*idx +: 8], so the first byte lands in the LSBs (little-endian); then idx increments.
  - On acceptance at idx=B-1, the completed word (current shift register plus this byte) is pushed into the output buffer, idx wraps to 0, and word_count_o increments (wraps modulo 2^count_width_p).
- Output buffer:
  - 2-entry FIFO; stream_v_o = not empty; stream_data_o = head.
  - A pop occurs on stream_v_o & stream_ready_i.
  - Latency: a word is visible on stream_v_o the cycle after its last byte is accepted.
- Flow control:
  - byte_ready_o = (idx != B-1) | ~fifo_full.
  - A push and a pop in the same cycle on a full FIFO is not permitted, because ready depends only on registered full. This gives no combinational path from stream_ready_i to byte_ready_o.
- Timeout (timeout_cycles_p > 0):
  - The idle counter increments each cycle with busy_o=1 and no byte accepted.
  - It clears on any accepted byte or when idx=0.
  - When it reaches timeout_cycles_p-1 with no byte accepted that cycle, the next edge sets idx=0, clears the shift register and the idle counter, and increments drop_count_o (saturating).
  - A byte accepted in the timeout cycle wins: no drop, and the counter clears.
  - The timeout never affects words already in the FIFO.
  - Back-pressure at idx=B-1 (FIFO full) counts as idle.
- Counters:
  - Counter widths are exact; there is no overflow indication.
  - word_count_o wraps; drop_count_o saturates.

Decomposition:
- Shared package (bp_common_pkg): the stream word width default and the little-endian lane-order constant, reused by the NBF loader bench.
- Sub-module: the 2-entry FIFO as bp_stream_two_fifo (width parameter, async active-low reset). The assembly FSM, timeout counter and counters stay in the top module.

Test Plan:
- Basic pack:
  - Stimulus: bytes 0x78,0x56,0x34,0x12 back-to-back, stream_ready_i=1.
  - Response: stream_data_o=0x12345678 valid exactly one cycle after the 4th byte; word_count_o=1; busy_o low afterwards.
- Back-pressure:
  - Stimulus: stream_ready_i=0; send 12 bytes (0x00..0x0B).
  - Response: two words 0x03020100 and 0x07060504 buffered. byte_ready_o drops at idx=3 of the third word and stays low until one pop, then word 0x0B0A0908 is accepted. No byte lost or duplicated.
- Timeout:
  - Stimulus: timeout_cycles_p=16; send 0xAA,0xBB, then idle 16 cycles; then 0x01,0x02,0x03,0x04.
  - Response: drop_count_o=1, busy_o=0 after 16 idle cycles; next word=0x04030201.
- Timeout tie:
  - Stimulus: timeout_cycles_p=16; partial word, 15 idle cycles, then a byte arrives in the cycle the counter hits 15.
  - Response: no drop, drop_count_o unchanged, idx advances.
- Async reset mid-word:
  - Stimulus: 3 bytes accepted plus 1 word buffered; pulse reset_n_i low between clock edges.
  - Response: all outputs 0 immediately, without waiting for an edge. After release, 0xDD,0xCC,0xBB,0xAA produces 0xAABBCCDD and word_count_o=1.
- Counter boundary:
  - Stimulus: count_width_p=4; push 17 words; force 17 timeouts.
  - Response: word_count_o=1 (wrapped), drop_count_o=0xF (saturated).
